// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, widths and
// the transfer-length helper used when a request is accepted.
package spi_pkg;

  localparam int SPI_MAX_BITS = 32;
  localparam int SPI_NBITS_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_LOW,
    ST_HIGH,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

  // Requested length field is "bits minus one"; anything past 31 is clamped to a full word.
  function automatic logic [SPI_NBITS_W-1:0] xfer_len(input logic [SPI_NBITS_W-1:0] nbits);
    return (nbits > 6'd31) ? 6'd32 : (nbits + 6'd1);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Sequencer-side request/response bundle of the SPI master.
// The master modport is the sequencer; the slave modport is spi_master.
interface spi_master_if;
  import spi_pkg::*;

  logic                           spi_request;
  logic [SPI_MAX_BITS-1:0]        spi_mosi_data;
  logic [SPI_NBITS_W-1:0]         spi_nbits;
  logic                           spi_ready;
  logic [SPI_MAX_BITS-1:0]        spi_miso_data;

  modport master (
    output spi_request, spi_mosi_data, spi_nbits,
    input  spi_ready, spi_miso_data
  );

  modport slave (
    input  spi_request, spi_mosi_data, spi_nbits,
    output spi_ready, spi_miso_data
  );

endinterface

// File: rtl/spi_half_period_timer.sv
// Half-period down-counter: reloads to CLK_DIV-1 on load, ticks on its last cycle.
// The FSM reloads it on every state change so each state lasts exactly CLK_DIV cycles.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst)
      cnt <= 8'd0;
    else if (load)
      cnt <= RELOAD;
    else
      cnt <= cnt - 8'd1;
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_master.sv
// Mode-3 SPI master: one full-duplex 1..32 bit transfer per request, MSB first,
// registered SCLK/CS_n/MOSI, one-cycle ready pulse carrying the received word.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic          clk_in,
  input  logic          nrst,
  spi_master_if.slave   bus,
  output logic          spi_sclk,
  output logic          spi_cs_n,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  spi_state_e                 state_q, state_d;
  logic [SPI_MAX_BITS-1:0]    tx_q, tx_d;
  logic [SPI_MAX_BITS-1:0]    rx_q, rx_d;
  logic [SPI_NBITS_W-1:0]     cnt_q, cnt_d;
  logic                       sclk_q, sclk_d;
  logic                       cs_n_q, cs_n_d;
  logic                       mosi_q, mosi_d;
  logic                       ready_q, ready_d;
  logic [SPI_MAX_BITS-1:0]    miso_q, miso_d;

  logic                       tick;
  logic                       accept;
  logic [SPI_NBITS_W-1:0]     len;
  logic [SPI_MAX_BITS-1:0]    tx_load;

  spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_in (clk_in),
    .nrst   (nrst),
    .load   ((state_q == ST_IDLE) || tick),
    .tick   (tick)
  );

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      miso_q  <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      miso_q  <= miso_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    ready_d = 1'b0;
    miso_d  = miso_q;
    accept  = 1'b0;
    // Left-align the word so the first bit to send always sits in tx[31].
    len     = xfer_len(bus.spi_nbits);
    tx_load = bus.spi_mosi_data << (6'd32 - len);

    case (state_q)
      ST_IDLE: accept = bus.spi_request;
      ST_LEAD: if (tick) begin
        sclk_d  = 1'b0;
        state_d = ST_LOW;
      end
      ST_LOW: if (tick) begin
        sclk_d  = 1'b1;
        rx_d    = {rx_q[SPI_MAX_BITS-2:0], spi_miso};
        cnt_d   = cnt_q - 6'd1;
        state_d = ST_HIGH;
      end
      ST_HIGH: if (tick) begin
        if (cnt_q != '0) begin
          sclk_d  = 1'b0;
          tx_d    = {tx_q[SPI_MAX_BITS-2:0], 1'b0};
          mosi_d  = tx_q[SPI_MAX_BITS-2];
          state_d = ST_LOW;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      ST_TRAIL: if (tick) begin
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = ST_GAP;
      end
      ST_GAP: if (tick) begin
        miso_d  = rx_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
        // The GAP exit edge doubles as the first IDLE sample, so a held
        // request restarts with exactly CLK_DIV cycles of CS high.
        accept  = bus.spi_request;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      tx_d    = tx_load;
      mosi_d  = tx_load[SPI_MAX_BITS-1];
      cnt_d   = len;
      rx_d    = '0;
      cs_n_d  = 1'b0;
      state_d = ST_LEAD;
    end
  end

  assign spi_sclk          = sclk_q;
  assign spi_cs_n          = cs_n_q;
  assign spi_mosi          = mosi_q;
  assign bus.spi_ready     = ready_q;
  assign bus.spi_miso_data = miso_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=4 and CLK_DIV=1 instances watched by
// one negedge monitor acting as the SPI slave (pattern or MOSI loopback).
module tb_spi_master;

  logic        clk_in = 1'b0;
  logic        nrst   = 1'b1;
  logic        req    = 1'b0;
  logic [5:0]  nbits_r = 6'd0;
  logic [31:0] data_r  = 32'd0;
  logic        sel     = 1'b0;
  logic        loop    = 1'b0;
  logic [31:0] pattern = 32'd0;

  logic cs0, sclk0, mosi0, cs1, sclk1, mosi1, miso;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  spi_master_if bus0();
  spi_master_if bus1();

  assign bus0.spi_request   = req & ~sel;
  assign bus0.spi_nbits     = nbits_r;
  assign bus0.spi_mosi_data = data_r;
  assign bus1.spi_request   = req & sel;
  assign bus1.spi_nbits     = nbits_r;
  assign bus1.spi_mosi_data = data_r;

  spi_master #(.CLK_DIV(4)) dut0 (
    .clk_in(clk_in), .nrst(nrst), .bus(bus0),
    .spi_sclk(sclk0), .spi_cs_n(cs0), .spi_mosi(mosi0), .spi_miso(miso)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk_in(clk_in), .nrst(nrst), .bus(bus1),
    .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(miso)
  );

  wire        cs_m    = sel ? cs1 : cs0;
  wire        sclk_m  = sel ? sclk1 : sclk0;
  wire        mosi_m  = sel ? mosi1 : mosi0;
  wire        ready_m = sel ? bus1.spi_ready : bus0.spi_ready;
  wire [31:0] rdata_m = sel ? bus1.spi_miso_data : bus0.spi_miso_data;

  // Slave monitor state
  int cyc = 0, cs_low = 0, redges = 0, ready_cnt = 0, ready_cyc = 0;
  int cs_fall_cyc = 0, cs_falls = 0, sclk_bad = 0, high_run = 0;
  logic [31:0] cap = 32'd0, pat_sr = 32'd0;
  logic cs_prev = 1'b1, sclk_prev = 1'b1;
  int gaps[$];

  assign miso = loop ? mosi_m : pat_sr[31];

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (!cs_m) cs_low++;
    if (cs_m && !sclk_m) sclk_bad++;
    if (cs_m) high_run++;
    if (cs_prev && !cs_m) begin
      cs_falls++; cs_fall_cyc = cyc; cap = 32'd0; redges = 0; pat_sr = pattern;
      gaps.push_back(high_run); high_run = 0;
    end
    if (!cs_m && !sclk_prev && sclk_m) begin
      cap = {cap[30:0], mosi_m}; redges++; pat_sr = {pat_sr[30:0], 1'b0};
    end
    if (ready_m) begin ready_cnt++; ready_cyc = cyc; end
    cs_prev = cs_m; sclk_prev = sclk_m;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input logic [5:0] nb, input logic [31:0] d);
    @(negedge clk_in);
    nbits_r = nb; data_r = d; req = 1'b1;
    @(negedge clk_in);
    req = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int lim);
    int base = ready_cnt;
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in); #1;
      if (ready_cnt > base) begin ok = 1'b1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
    #1;
  endtask

  initial begin
    int low0, rdy0, fall0, gbase;
    bit ok;

    #1 nrst = 1'b0;
    @(negedge clk_in); #1;
    chk("rst_cs_n", 64'(cs0), 64'd1);
    chk("rst_sclk", 64'(sclk0), 64'd1);
    chk("rst_mosi", 64'(mosi0), 64'd0);
    chk("rst_ready", 64'(bus0.spi_ready), 64'd0);
    chk("rst_rdata", 64'(bus0.spi_miso_data), 64'd0);
    chk("rst1_cs_sclk", {62'd0, cs1, sclk1}, 64'd3);
    nrst = 1'b1;
    idle(3);

    // WHO_AM_I read, slave returns 0x00 then 0x33
    pattern = 32'h0033_0000; loop = 1'b0;
    low0 = cs_low; rdy0 = ready_cnt;
    pulse_req(6'd15, 32'h0000_8F00);
    wait_ready("who_ready", 400);
    idle(3);
    chk("who_mosi", 64'(cap[15:0]), 64'h8F00);
    chk("who_edges", 64'(redges), 64'd16);
    chk("who_cs_low", 64'(cs_low - low0), 64'd136);
    chk("who_latency", 64'(ready_cyc - cs_fall_cyc), 64'd140);
    chk("who_ready_cnt", 64'(ready_cnt - rdy0), 64'd1);
    chk("who_rdata", 64'(rdata_m), 64'h33);

    // 24-bit register write
    pattern = 32'd0;
    low0 = cs_low;
    pulse_req(6'd23, 32'h000A_2D02);
    wait_ready("w24_ready", 500);
    idle(3);
    chk("w24_mosi", 64'(cap[23:0]), 64'h0A2D02);
    chk("w24_edges", 64'(redges), 64'd24);
    chk("w24_cs_low", 64'(cs_low - low0), 64'd200);
    chk("w24_rdata", 64'(rdata_m), 64'd0);

    // Length boundaries with MISO looped to MOSI
    loop = 1'b1;
    pulse_req(6'd0, 32'h1234_5671);
    wait_ready("n1_ready", 100);
    idle(3);
    chk("n1_edges", 64'(redges), 64'd1);
    chk("n1_rdata", 64'(rdata_m), 64'h1);

    pulse_req(6'd31, 32'hA5A5_5A5A);
    wait_ready("n32_ready", 600);
    idle(3);
    chk("n32_edges", 64'(redges), 64'd32);
    chk("n32_rdata", 64'(rdata_m), 64'hA5A55A5A);

    low0 = cs_low;
    pulse_req(6'd40, 32'h3C3C_C3C3);
    wait_ready("n40_ready", 600);
    idle(3);
    chk("n40_edges", 64'(redges), 64'd32);
    chk("n40_rdata", 64'(rdata_m), 64'h3C3CC3C3);
    chk("n40_cs_low", 64'(cs_low - low0), 64'd264);

    // Request pulse during a transfer is dropped
    rdy0 = ready_cnt; fall0 = cs_falls;
    pulse_req(6'd15, 32'h0000_1234);
    idle(30);
    pulse_req(6'd3, 32'hFFFF_FFFF);
    wait_ready("mid_ready", 400);
    idle(200);
    chk("mid_ready_cnt", 64'(ready_cnt - rdy0), 64'd1);
    chk("mid_cs_falls", 64'(cs_falls - fall0), 64'd1);
    chk("mid_rdata", 64'(rdata_m), 64'h1234);
    chk("mid_cs_idle", 64'(cs0), 64'd1);

    // Held request: back-to-back transfers
    rdy0 = ready_cnt; fall0 = cs_falls; gbase = gaps.size();
    @(negedge clk_in);
    nbits_r = 6'd7; data_r = 32'h0000_00C3; req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in); #1;
      if (ready_cnt - rdy0 >= 3) begin ok = 1'b1; break; end
    end
    req = 1'b0;
    chk("held_three", 64'(ok), 64'd1);
    wait_ready("held_last", 200);
    idle(20);
    chk("held_ready_cnt", 64'(ready_cnt - rdy0), 64'd4);
    chk("held_cs_falls", 64'(cs_falls - fall0), 64'd4);
    for (int g = 1; g <= 3; g++)
      chk($sformatf("held_gap%0d", g),
          64'((gaps.size() > gbase + g) ? gaps[gbase + g] : -1), 64'd4);
    chk("held_rdata", 64'(rdata_m), 64'hC3);

    // Asynchronous reset in the middle of bit 5
    pulse_req(6'd15, 32'h0000_FFFF);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in); #1;
      if (redges >= 5) begin ok = 1'b1; break; end
    end
    chk("arst_reach_bit5", 64'(ok), 64'd1);
    @(posedge clk_in); #2;
    nrst = 1'b0;
    #1;
    chk("arst_cs_n", 64'(cs0), 64'd1);
    chk("arst_sclk", 64'(sclk0), 64'd1);
    chk("arst_mosi", 64'(mosi0), 64'd0);
    chk("arst_ready", 64'(bus0.spi_ready), 64'd0);
    chk("arst_rdata", 64'(bus0.spi_miso_data), 64'd0);
    @(negedge clk_in);
    nrst = 1'b1;
    idle(3);
    pulse_req(6'd15, 32'h0000_BEEF);
    wait_ready("post_rst_ready", 400);
    idle(3);
    chk("post_rst_edges", 64'(redges), 64'd16);
    chk("post_rst_latency", 64'(ready_cyc - cs_fall_cyc), 64'd140);
    chk("post_rst_rdata", 64'(rdata_m), 64'hBEEF);

    // CLK_DIV=1 WHO_AM_I
    sel = 1'b1; loop = 1'b0; pattern = 32'h0033_0000;
    idle(2);
    low0 = cs_low;
    pulse_req(6'd15, 32'h0000_8F00);
    wait_ready("div1_ready", 100);
    idle(3);
    chk("div1_mosi", 64'(cap[15:0]), 64'h8F00);
    chk("div1_edges", 64'(redges), 64'd16);
    chk("div1_cs_low", 64'(cs_low - low0), 64'd34);
    chk("div1_latency", 64'(ready_cyc - cs_fall_cyc), 64'd35);
    chk("div1_rdata", 64'(rdata_m), 64'h33);

    chk("sclk_high_when_cs_high", 64'(sclk_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
